// File: rtl/text_buffer_ctrl_if.sv
// ---------------------------------------------------------------------------
// text_buffer_ctrl_if
// Byte-stream handshake into the text buffer controller.
//   ch_valid : producer has a byte on ch_data
//   ch_ready : controller accepts the byte on this cycle
//   ch_data  : character code / control byte
// Modports: master = byte producer, slave = text_buffer_ctrl.
// ---------------------------------------------------------------------------
interface text_buffer_ctrl_if #(
  parameter int ID_W = 8
) ();
  logic            ch_valid;
  logic            ch_ready;
  logic [ID_W-1:0] ch_data;

  modport master (output ch_valid, output ch_data, input ch_ready);
  modport slave  (input ch_valid, input ch_data, output ch_ready);
endinterface

// File: rtl/text_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// text_buffer_ctrl
// Character-cell text buffer (ROWS x COLS character IDs) with a hardware
// cursor and a write sequencer for multi-cycle CLEAR and SCROLL operations.
// The input byte stream is stalled (ch_ready low) while a sequence runs.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; restarts the power-up CLEAR
//   ch         : byte stream handshake (text_buffer_ctrl_if.slave)
//   rd_row/col : pixel-encoder character cell address
//   rd_id      : character ID at (rd_row, rd_col), combinational
//   cursor_row/cursor_col : current cursor position
//   busy       : CLEAR or SCROLL sequence in progress
//
// Optional feature macro: CURSOR_BLINK_EN
//   Defined   : blinking CURSOR_ID overlay at the cursor cell while idle.
//   Undefined : rd_id always returns the stored cell.
// ---------------------------------------------------------------------------
module text_buffer_ctrl #(
  parameter int              ROWS         = 7,
  parameter int              COLS         = 20,
  parameter int              ROW_W        = 4,
  parameter int              COL_W        = 6,
  parameter int              ID_W         = 8,
  parameter logic [ID_W-1:0] BLANK_ID     = 8'h20,
  parameter logic [ID_W-1:0] CURSOR_ID    = 8'h5F,
  parameter int              BLINK_CYCLES = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  text_buffer_ctrl_if.slave ch,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [ID_W-1:0]   rd_id,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col,
  output logic              busy
);

  localparam int CELLS       = ROWS * COLS;
  localparam int SCROLL_COPY = (ROWS - 1) * COLS;
  localparam int CNT_W       = 8;

  typedef logic [CNT_W-1:0] idx_t;
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_SCROLL} state_t;

  // The 8-bit sequence counter doubles as the linear cell index.
  if (CELLS > 256 || BLINK_CYCLES < 1 || CURSOR_ID == BLANK_ID) begin : g_param_check
    $error("text_buffer_ctrl: invalid parameter set");
  end

  state_t           r_state;
  idx_t             r_cnt;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_ready;
  logic             r_busy;
  logic [ID_W-1:0]  r_mem [CELLS];

  // Byte decode
  logic w_accept, w_is_print, w_is_nl, w_is_bs, w_is_ff;
  logic w_row_last, w_col_last, w_at_origin, w_line_feed, w_last_cell;
  idx_t w_cur_idx;

  assign w_accept    = ch.ch_valid && r_ready;
  assign w_is_print  = ch.ch_data >= ID_W'(8'h20);
  assign w_is_nl     = (ch.ch_data == ID_W'(8'h0A)) || (ch.ch_data == ID_W'(8'h0D));
  assign w_is_bs     = ch.ch_data == ID_W'(8'h08);
  assign w_is_ff     = ch.ch_data == ID_W'(8'h0C);
  assign w_row_last  = r_row == ROW_W'(ROWS - 1);
  assign w_col_last  = r_col == COL_W'(COLS - 1);
  assign w_at_origin = (r_row == '0) && (r_col == '0);
  // Printable at the last column wraps exactly like a newline.
  assign w_line_feed = w_is_nl || (w_is_print && w_col_last);
  assign w_last_cell = r_cnt == idx_t'(CELLS - 1);
  assign w_cur_idx   = idx_t'(r_row) * idx_t'(COLS) + idx_t'(r_col);

  // Single write port, owned by the sequencer
  logic            w_we;
  idx_t            w_waddr;
  logic [ID_W-1:0] w_wdata;
  logic            w_copy;
  idx_t            w_src;

  assign w_copy = r_cnt < idx_t'(SCROLL_COPY);
  assign w_src  = r_cnt + idx_t'(COLS);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = BLANK_ID;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_print) begin
            w_we    = 1'b1;
            w_waddr = w_cur_idx;
            w_wdata = ch.ch_data;
          end else if (w_is_bs && !w_at_origin) begin
            // Stepping back one cell is always linear index - 1, even across
            // a row boundary.
            w_we    = 1'b1;
            w_waddr = w_cur_idx - idx_t'(1);
          end
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
      end
      ST_SCROLL: begin
        // Copy cell i+COLS down to i; the source is never overwritten
        // before it is read because the index only increases.
        w_we    = 1'b1;
        w_waddr = r_cnt;
        if (w_copy) w_wdata = r_mem[w_src];
      end
      default: ;
    endcase
    if (reset) w_we = 1'b0;
  end

  // NOTE: the cell array has no reset; the CLEAR sequence that follows every
  // reset initializes it, which keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_print) begin
              r_col <= w_col_last ? '0 : r_col + COL_W'(1);
            end else if (w_is_nl) begin
              r_col <= '0;
            end else if (w_is_bs && !w_at_origin) begin
              if (r_col != '0) begin
                r_col <= r_col - COL_W'(1);
              end else begin
                r_row <= r_row - ROW_W'(1);
                r_col <= COL_W'(COLS - 1);
              end
            end else if (w_is_ff) begin
              r_state <= ST_CLEAR;
              r_cnt   <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
            if (w_line_feed) begin
              if (w_row_last) begin
                r_state <= ST_SCROLL;
                r_cnt   <= '0;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
              end else begin
                r_row <= r_row + ROW_W'(1);
              end
            end
          end
        end
        ST_CLEAR: begin
          if (w_last_cell) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + idx_t'(1);
          end
        end
        ST_SCROLL: begin
          if (w_last_cell) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_row   <= ROW_W'(ROWS - 1);
            r_col   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + idx_t'(1);
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Read path: out-of-range addresses show a blank cell.
  logic            w_rd_in;
  idx_t            w_rd_idx;
  logic [ID_W-1:0] w_cell;

  assign w_rd_in  = (rd_row < ROW_W'(ROWS)) && (rd_col < COL_W'(COLS));
  assign w_rd_idx = w_rd_in ? idx_t'(rd_row) * idx_t'(COLS) + idx_t'(rd_col) : '0;
  assign w_cell   = w_rd_in ? r_mem[w_rd_idx] : BLANK_ID;

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;

  // Any accepted byte restarts the visible half-period so typing never
  // lands on a hidden cursor.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign rd_id = ((r_state == ST_IDLE) && r_phase && (rd_row == r_row) && (rd_col == r_col))
               ? CURSOR_ID : w_cell;
`else
  assign rd_id = w_cell;
`endif

  assign ch.ch_ready = r_ready;
  assign busy        = r_busy;
  assign cursor_row  = r_row;
  assign cursor_col  = r_col;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_buffer_ctrl
// Scoreboard bench for text_buffer_ctrl. A behavioural model of the grid and
// cursor produces expected cell contents; expected cells are queued when a
// byte is driven (or a full grid snapshot is requested) and compared against
// rd_id when the DUT is expected to show them.
// Define CURSOR_BLINK_EN to also exercise the cursor blink overlay.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_text_buffer_ctrl;

  localparam int ROWS = 7;
  localparam int COLS = 20;
`ifdef CURSOR_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] rd_row;
  logic [5:0] rd_col;
  logic [7:0] rd_id;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  text_buffer_ctrl_if #(.ID_W(8)) ch_if ();

  text_buffer_ctrl #(.BLINK_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch         (ch_if.slave),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_id      (rd_id),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  typedef struct {
    int         idx;
    logic [7:0] id;
  } exp_t;

  logic [7:0] m_mem [ROWS*COLS];
  int         m_row, m_col;
  exp_t       sb_q[$];

  task automatic model_reset();
    for (int i = 0; i < ROWS*COLS; i++) m_mem[i] = 8'h20;
    m_row = 0;
    m_col = 0;
    sb_q.delete();
  endtask

  task automatic model_scroll();
    for (int i = 0; i < (ROWS-1)*COLS; i++) m_mem[i] = m_mem[i+COLS];
    for (int i = (ROWS-1)*COLS; i < ROWS*COLS; i++) m_mem[i] = 8'h20;
    m_row = ROWS-1;
    m_col = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (b >= 8'h20) begin
      e.idx = m_row*COLS + m_col;
      e.id  = b;
      m_mem[e.idx] = b;
      sb_q.push_back(e);
      if (m_col == COLS-1) begin
        m_col = 0;
        if (m_row == ROWS-1) model_scroll();
        else m_row++;
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A || b == 8'h0D) begin
      m_col = 0;
      if (m_row == ROWS-1) model_scroll();
      else m_row++;
    end else if (b == 8'h08) begin
      if (m_row != 0 || m_col != 0) begin
        if (m_col > 0) m_col--;
        else begin
          m_row--;
          m_col = COLS-1;
        end
        e.idx = m_row*COLS + m_col;
        e.id  = 8'h20;
        m_mem[e.idx] = 8'h20;
        sb_q.push_back(e);
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < ROWS*COLS; i++) m_mem[i] = 8'h20;
      m_row = 0;
      m_col = 0;
    end
  endtask

  // With the blink overlay present the idle cursor cell reads CURSOR_ID
  // half the time, so the stored-content checks leave it out.
  function automatic bit masked(input int r, input int c);
    return BLINK_BUILD && (r == m_row) && (c == m_col);
  endfunction

  task automatic push_grid();
    exp_t e;
    for (int i = 0; i < ROWS*COLS; i++) begin
      e.idx = i;
      e.id  = m_mem[i];
      sb_q.push_back(e);
    end
  endtask

  // Pop expected cells and compare them with rd_id; called at a falling edge.
  task automatic drain_sb(input string tag);
    exp_t e;
    int   r, c;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      r = e.idx / COLS;
      c = e.idx % COLS;
      if (!masked(r, c)) begin
        rd_row = 4'(r);
        rd_col = 6'(c);
        #1;
        total++;
        if (rd_id !== e.id) begin
          bad++;
          $display("FAIL %s cell(%0d,%0d) got=%02h want=%02h", tag, r, c, rd_id, e.id);
        end
      end
      if (sb_q.size() > 0) @(negedge clk);
    end
  endtask

  // Drive one byte and leave ch_valid high; returns at the falling edge of
  // the cycle after acceptance, where the write must already be visible.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ch_if.ch_valid = 1'b1;
    ch_if.ch_data  = b;
    while (ch_if.ch_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ch_if.ch_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout byte=%02h ready=%b after %0d cycles", b, ch_if.ch_ready, n);
      return;
    end
    @(negedge clk);
    model_byte(b);
    drain_sb("write");
  endtask

  // Counts cycles (sampled at falling edges) with ch_ready low.
  task automatic wait_ready(output int n);
    n = 0;
    while (ch_if.ch_ready !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    int orow [3];
    int ocol [3];
    orow = '{7, 0, 15};
    ocol = '{0, 20, 63};
    reset = 1'b1;
    ch_if.ch_valid = 1'b0;
    ch_if.ch_data  = 8'h00;
    rd_row = '0;
    rd_col = '0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
    total++;
    if (ch_if.ch_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ch_if.ch_ready); end
    total++;
    if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
      bad++; $display("FAIL reset_cursor got=(%0d,%0d) want=(0,0)", cursor_row, cursor_col);
    end
    reset = 1'b0;
    wait_ready(n);
    total++;
    if (n != 140) begin bad++; $display("FAIL reset_clear_len got=%0d want=140", n); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b want=0", busy); end
    model_reset();
    push_grid();
    drain_sb("reset_grid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_row = 4'(orow[i]);
      rd_col = 6'(ocol[i]);
      #1;
      total++;
      if (rd_id !== 8'h20) begin
        bad++; $display("FAIL out_of_range (%0d,%0d) got=%02h want=20", orow[i], ocol[i], rd_id);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_print();
    send_byte(8'h41);
    send_byte(8'h42);
    ch_if.ch_valid = 1'b0;
    total++;
    if (cursor_row !== 4'd0 || cursor_col !== 6'd2) begin
      bad++; $display("FAIL print_cursor got=(%0d,%0d) want=(0,2)", cursor_row, cursor_col);
    end
    @(negedge clk);
  endtask

  task automatic test_backspace();
    send_byte(8'h08);
    send_byte(8'h08);
    send_byte(8'h08);
    ch_if.ch_valid = 1'b0;
    total++;
    if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
      bad++; $display("FAIL bs_origin_cursor got=(%0d,%0d) want=(0,0)", cursor_row, cursor_col);
    end
    @(negedge clk);
    push_grid();
    drain_sb("bs_grid");
    @(negedge clk);
    send_byte(8'h0A);
    send_byte(8'h08);
    send_byte(8'h01);
    ch_if.ch_valid = 1'b0;
    total++;
    if (cursor_row !== 4'd0 || cursor_col !== 6'd19) begin
      bad++; $display("FAIL bs_wrap_cursor got=(%0d,%0d) want=(0,19)", cursor_row, cursor_col);
    end
    @(negedge clk);
  endtask

  task automatic test_fill_scroll();
    int n;
    send_byte(8'h0C);
    ch_if.ch_valid = 1'b0;
    wait_ready(n);
    total++;
    if (n != 140) begin bad++; $display("FAIL ff_clear_len got=%0d want=140", n); end
    total++;
    if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
      bad++; $display("FAIL ff_cursor got=(%0d,%0d) want=(0,0)", cursor_row, cursor_col);
    end
    for (int i = 0; i < ROWS*COLS; i++) send_byte(8'h30 + 8'(i % 10));
    ch_if.ch_valid = 1'b0;
    wait_ready(n);
    total++;
    if (n != 140) begin bad++; $display("FAIL scroll_len got=%0d want=140", n); end
    total++;
    if (cursor_row !== 4'd6 || cursor_col !== 6'd0) begin
      bad++; $display("FAIL scroll_cursor got=(%0d,%0d) want=(6,0)", cursor_row, cursor_col);
    end
    push_grid();
    drain_sb("scroll_grid");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scroll();
    int n;
    for (int i = 0; i < COLS; i++) send_byte(8'h61 + 8'(i));
    // ch_valid stays high with junk data through the scroll and the reset
    ch_if.ch_data = 8'h55;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || ch_if.ch_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_flags got busy=%b ready=%b want busy=1 ready=0", busy, ch_if.ch_ready);
    end
    total++;
    if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
      bad++; $display("FAIL midreset_cursor got=(%0d,%0d) want=(0,0)", cursor_row, cursor_col);
    end
    reset = 1'b0;
    wait_ready(n);
    ch_if.ch_valid = 1'b0;
    total++;
    if (n != 140) begin bad++; $display("FAIL midreset_clear_len got=%0d want=140", n); end
    model_reset();
    push_grid();
    drain_sb("midreset_grid");
    @(negedge clk);
  endtask

`ifdef CURSOR_BLINK_EN
  task automatic test_blink();
    logic [7:0] want;
    send_byte(8'h0A);
    send_byte(8'h0A);
    send_byte(8'h78);
    send_byte(8'h79);
    send_byte(8'h7A);
    ch_if.ch_valid = 1'b0;
    total++;
    if (cursor_row !== 4'd2 || cursor_col !== 6'd3) begin
      bad++; $display("FAIL blink_cursor got=(%0d,%0d) want=(2,3)", cursor_row, cursor_col);
    end
    rd_row = 4'd2;
    rd_col = 6'd3;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      want = ((i / 4) % 2 == 0) ? 8'h5F : m_mem[2*COLS+3];
      total++;
      if (rd_id !== want) begin bad++; $display("FAIL blink_phase i=%0d got=%02h want=%02h", i, rd_id, want); end
    end
    send_byte(8'h01);
    ch_if.ch_valid = 1'b0;
    rd_row = 4'd2;
    rd_col = 6'd3;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      want = (j < 4) ? 8'h5F : m_mem[2*COLS+3];
      total++;
      if (rd_id !== want) begin bad++; $display("FAIL blink_restart j=%0d got=%02h want=%02h", j, rd_id, want); end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_print();
    test_backspace();
    test_fill_scroll();
    test_reset_mid_scroll();
`ifdef CURSOR_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/text_buffer_ctrl.md
# text_buffer_ctrl

Character-cell text buffer and write sequencer for the 640x480 character display. Holds the 7-row x 20-column grid of 8-bit character IDs that the pixel encoder looks up by character row/column. Accepts a byte stream (printable codes plus a small control set), writes characters at a hardware cursor, and sequences multi-cycle clear and scroll operations. While a sequence runs, it stalls the input stream.

## Interface
Parameters:
- ROWS, 7, text rows
- COLS, 20, characters per row
- ROW_W, 4, row index width
- COL_W, 6, column index width
- ID_W, 8, character ID width
- BLANK_ID, 8'h20, ID written by clear, scroll-fill and backspace
- CURSOR_ID, 8'h5F, ID shown at the cursor cell when blink phase is on (CURSOR_EN only)
- BLINK_CYCLES, 12_500_000, clocks per blink half-period (CURSOR_EN only)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- ch_valid  in  1  input byte valid
- ch_ready  out  1  block can accept a byte this cycle
- ch_data  in  ID_W  input byte
- rd_row  in  ROW_W  pixel-encoder character row
- rd_col  in  COL_W  pixel-encoder character column
- rd_id  out  ID_W  character ID at (rd_row, rd_col); combinational
- cursor_row  out  ROW_W  current cursor row
- cursor_col  out  COL_W  current cursor column
- busy  out  1  CLEAR or SCROLL sequence in progress

## Operation
- Storage: ROWS*COLS cells, linear index = row*COLS + col. Single write port owned by the FSM.
- FSM states are IDLE, CLEAR and SCROLL.
- ch_ready = (state==IDLE). A byte is accepted on a cycle where ch_valid && ch_ready.
- Accepted byte decode, in IDLE:
  - 0x20..0xFF (printable): write ch_data at the cursor, then advance the cursor.
  - Advance rule: col+1. If col==COLS-1, set col=0 and row+1. If row was ROWS-1, enter SCROLL.
  - 0x0A or 0x0D (newline): col=0, row+1. If row==ROWS-1, enter SCROLL.
  - 0x08 (backspace):
    - If col>0: col-1.
    - Else if row>0: row-1, col=COLS-1.
    - Then write BLANK_ID at the new cursor position.
    - At (0,0): no-op.
  - 0x0C (form feed): enter CLEAR and set cursor to (0,0).
  - Any other code below 0x20: consumed with no effect.
- CLEAR: write BLANK_ID to indices 0..ROWS*COLS-1, one cell per cycle (140 cycles), then return to IDLE.
- SCROLL:
  - Copy cell i+COLS to cell i for i=0..(ROWS-1)*COLS-1, one cell per cycle (120 cycles).
  - Then write BLANK_ID to the last row (20 cycles), for 140 cycles total.
  - Cursor is (ROWS-1, 0) on return to IDLE.
- rd_id returns BLANK_ID when rd_row>=ROWS or rd_col>=COLS. During CLEAR/SCROLL it shows partially updated contents; this is acceptable.

## Timing
- Reset values:
  - ch_ready=0, busy=1, cursor=(0,0), state=CLEAR with the sequence counter at 0.
  - The power-up clear therefore completes 140 cycles after reset deasserts.
  - Reset asserted mid-CLEAR or mid-SCROLL aborts the sequence and restarts CLEAR from index 0.
- A printable write is visible on rd_id the cycle after acceptance. The cursor updates in the same cycle.
- Entering SCROLL: the triggering character is written first in its accept cycle. ch_ready falls the next cycle and stays low for exactly 140 cycles.
- busy = (state!=IDLE). No byte is accepted while busy, and ch_data is ignored.
- Counter width is 8 bits. ROWS*COLS must not exceed 256.

## Configuration
- CURSOR_BLINK_EN defined:
  - A blink counter counts 0..BLINK_CYCLES-1 and toggles a phase bit on wrap.
  - Phase resets to 1 (visible) with counter 0 on reset and on every accepted byte.
  - When state==IDLE, phase==1 and (rd_row,rd_col)==cursor, rd_id returns CURSOR_ID instead of the stored cell.
- Not defined: no counter or phase logic. rd_id always returns the stored cell.

## Test plan
- Reset, wait 140 cycles -> busy falls, ch_ready=1, and every in-range cell reads 0x20. Reading (7,0) or (0,20) -> 0x20.
- Send 0x41 then 0x42 -> cells (0,0)=0x41 and (0,1)=0x42, cursor=(0,2). Each write is visible one cycle after acceptance.
- From (0,1), send 0x08 -> cursor (0,0), cell (0,0)=0x20. Send 0x08 again at (0,0) -> no change.
- Fill 140 printable bytes 0x30+(i%10) with ch_valid held high:
  - After the last byte, ch_ready stays low for 140 cycles.
  - Row 0 then holds the former row 1, row 6 is all 0x20, and cursor=(6,0).
- With ch_valid held high, assert reset at cycle 50 of a SCROLL -> CLEAR restarts. ch_ready returns 140 cycles after reset deasserts, with all cells 0x20.
- CURSOR_BLINK_EN with BLINK_CYCLES=4, idle at (2,3):
  - Reading (2,3) gives 0x5F for 4 cycles, then the stored ID for 4 cycles, alternating.
  - An accepted byte forces 0x5F visible again.
